// File: rtl/v_shift_serializer_ctrl.sv
// Parallel-to-serial transmit controller: accepts words over valid/ready and
// shifts them out on SO at one bit per (div+1) clocks, back-to-back capable.
module v_shift_serializer_ctrl #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIV_W     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             abort,
    output logic             SO,
    output logic             so_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_shifted;
    logic [CNT_W-1:0] bit_cnt;
    logic [DIV_W-1:0] div_cnt, div_lat;
    logic             tick, last, accept;

    assign tick   = (state == SHIFT) && (div_cnt == '0);
    assign last   = (bit_cnt == CNT_W'(WIDTH - 1));
    assign accept = din_valid && din_ready;

    // SO is taken straight from the output end of the register, so clearing
    // shreg is what forces SO low when the word ends or is aborted.
    assign SO = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (abort)                        state_nxt = IDLE;
                else if (tick && last && !accept) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        din_ready = !abort && ((state == IDLE) || (tick && last));
        busy      = (state == SHIFT);
        so_valid  = (state == SHIFT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            div_lat <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state == SHIFT) && abort) begin
                shreg   <= '0;
                bit_cnt <= '0;
                div_cnt <= '0;
            end else if (accept) begin
                // An accept while shifting can only happen on the final tick.
                shreg   <= din;
                div_lat <= div;
                div_cnt <= div;
                bit_cnt <= '0;
                done    <= tick && last;
            end else if (tick) begin
                if (last) begin
                    shreg <= '0;
                    done  <= 1'b1;
                end else begin
                    shreg   <= shreg_shifted;
                    bit_cnt <= bit_cnt + 1'b1;
                    div_cnt <= div_lat;
                end
            end else if (state == SHIFT) begin
                div_cnt <= div_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_v_shift_serializer_ctrl.sv
// Bench for v_shift_serializer_ctrl: timeline model of word start/length plus
// directed literal scenarios and a randomized phase.
module tb_v_shift_serializer_ctrl;

    localparam int WIDTH = 8;
    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [DIV_W-1:0] div = '0;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             din_ready;
    logic             abort = 1'b0;
    logic             SO, so_valid, busy, done;

    int checks = 0;
    int failures = 0;

    v_shift_serializer_ctrl #(
        .WIDTH(WIDTH),
        .DIV_W(DIV_W),
        .MSB_FIRST(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .div(div), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .abort(abort), .SO(SO), .so_valid(so_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: a word accepted in cycle t0 with divider d occupies cycles
    // t0+1 .. t0+WIDTH*(d+1); bit k is on SO for cycles t0+1+k*(d+1) .. +d.
    bit             m_busy = 1'b0;
    int             m_t0 = 0;
    int             m_div = 0;
    logic [WIDTH-1:0] m_word = '0;
    int             m_done_at = -1;
    int             cyc = 0;

    always @(negedge clk) begin
        int   len, k;
        logic exp_so, exp_ready, endw;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done_at = -1;
            chk("rst_so", SO, 0);
            chk("rst_so_valid", so_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
        end else begin
            len = WIDTH * (m_div + 1);
            endw = m_busy && (cyc == m_t0 + len);
            exp_so = 1'b0;
            if (m_busy) begin
                k = (cyc - m_t0 - 1) / (m_div + 1);
                exp_so = m_word[WIDTH-1-k];
            end
            exp_ready = !abort && (!m_busy || endw);
            chk("m_so", SO, exp_so);
            chk("m_so_valid", so_valid, m_busy);
            chk("m_busy", busy, m_busy);
            chk("m_ready", din_ready, exp_ready);
            chk("m_done", done, cyc == m_done_at);
            if (m_busy && abort) begin
                m_busy = 1'b0;
            end else begin
                if (endw) begin
                    m_done_at = cyc + 1;
                    m_busy = 1'b0;
                end
                if (din_valid && exp_ready) begin
                    m_busy = 1'b1;
                    m_t0 = cyc;
                    m_word = din;
                    m_div = int'(div);
                end
            end
        end
        cyc++;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] pat;
        logic [15:0]      pat16;
        logic             acc;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            nxt();
            chk("idle_ready", din_ready, 1);
            chk("idle_so", SO, 0);
            chk("idle_busy", busy, 0);
        end

        // Single word, div=0
        pat = 8'hA5;
        din = pat; div = 0; din_valid = 1'b1;
        #1 chk("a5_ready", din_ready, 1);
        nxt(); din_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 8) begin
                chk("a5_so", SO, pat[8-c]);
                chk("a5_so_valid", so_valid, 1);
            end else begin
                chk("a5_busy_end", busy, 0);
            end
            chk("a5_done", done, c == 9);
            nxt();
        end
        repeat (2) nxt();

        // Divided rate, div change mid-word ignored
        din = 8'h81; div = 2; din_valid = 1'b1;
        nxt(); din_valid = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            if (c == 10) div = 5;
            if (c <= 24) chk("div_so", SO, (c <= 3) || (c >= 22));
            chk("div_done", done, c == 25);
            nxt();
        end
        repeat (2) nxt();

        // Back-to-back words with no gap
        pat16 = 16'hF00F;
        din = 8'hF0; div = 0; din_valid = 1'b1;
        #1 chk("b2b_ready0", din_ready, 1);
        nxt(); din = 8'h0F;
        for (int c = 1; c <= 17; c++) begin
            #1;
            if (c <= 15) chk("b2b_ready", din_ready, c == 8);
            if (c <= 16) begin
                chk("b2b_so", SO, pat16[16-c]);
                chk("b2b_busy", busy, 1);
            end
            chk("b2b_done", done, (c == 9) || (c == 17));
            nxt();
            if (c == 8) din_valid = 1'b0;
        end
        repeat (2) nxt();

        // Abort mid-word, then a clean restart
        din = 8'hFF; div = 1; din_valid = 1'b1;
        nxt(); din_valid = 1'b0;
        repeat (5) nxt();
        abort = 1'b1;
        #1 chk("abt_ready_blk", din_ready, 0);
        nxt();
        abort = 1'b0; din = 8'h80; div = 0; din_valid = 1'b1;
        #1;
        chk("abt_so", SO, 0);
        chk("abt_busy", busy, 0);
        chk("abt_done", done, 0);
        chk("abt_ready", din_ready, 1);
        nxt(); din_valid = 1'b0;
        chk("abt_new_so", SO, 1);
        chk("abt_new_busy", busy, 1);
        repeat (12) nxt();

        // Asynchronous reset in the middle of a word
        din = 8'h55; div = 3; din_valid = 1'b1;
        nxt(); din_valid = 1'b0;
        repeat (9) nxt();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_so", SO, 0);
        chk("ar_so_valid", so_valid, 0);
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) begin
            nxt();
            chk("ar_post_ready", din_ready, 1);
            chk("ar_post_done", done, 0);
        end

        // Randomized traffic; producer holds din until it is taken
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            acc = din_valid && din_ready;
            @(posedge clk);
            #1;
            if (acc || !din_valid) begin
                din_valid = ($urandom_range(0, 2) != 0);
                din = WIDTH'($urandom);
            end
            div = DIV_W'($urandom_range(0, 3));
            abort = ($urandom_range(0, 29) == 0);
        end
        din_valid = 1'b0;
        abort = 1'b0;
        repeat (50) nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
